// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-master memory read arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_arb_pkg;

    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 8;
    localparam int DATA_W  = 64;
    localparam int BURST_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // One captured read-address request.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

endpackage

// File: rtl/mem_read_arbiter.sv
// Two-master AXI4 read arbiter (video = master 0, CPU = master 1) onto one memory read port.
// Latency: request in IDLE -> m_ar_valid next cycle; R beats pass through with 0 cycles.
// Backpressure: one burst outstanding; AR held until m_ar_ready; m_r_ready follows the owner's r_ready.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   s0_ar_* / s0_r_*      video master address request and read data
//   s1_ar_* / s1_r_*      CPU master address request and read data
//   m_ar_* / m_r_*        memory-side address request and read data
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_VIDEO_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              s0_ar_valid,
    output logic              s0_ar_ready,
    input  logic [ADDR_W-1:0] s0_ar_payload_addr,
    input  logic [LEN_W-1:0]  s0_ar_payload_len,
    input  logic [1:0]        s0_ar_payload_burst,
    output logic              s0_r_valid,
    input  logic              s0_r_ready,
    output logic [DATA_W-1:0] s0_r_payload_data,
    output logic              s0_r_payload_last,

    input  logic              s1_ar_valid,
    output logic              s1_ar_ready,
    input  logic [ADDR_W-1:0] s1_ar_payload_addr,
    input  logic [LEN_W-1:0]  s1_ar_payload_len,
    input  logic [1:0]        s1_ar_payload_burst,
    output logic              s1_r_valid,
    input  logic              s1_r_ready,
    output logic [DATA_W-1:0] s1_r_payload_data,
    output logic              s1_r_payload_last,

    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [ADDR_W-1:0] m_ar_payload_addr,
    output logic [LEN_W-1:0]  m_ar_payload_len,
    output logic [1:0]        m_ar_payload_burst,
    input  logic              m_r_valid,
    output logic              m_r_ready,
    input  logic [DATA_W-1:0] m_r_payload_data,
    input  logic              m_r_payload_last
);

    localparam int                  STREAK_W   = $clog2(MAX_VIDEO_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VIDEO_STREAK);

    arb_state_t          state, state_nxt;
    logic                owner, owner_nxt;     // 0 = video, 1 = CPU
    logic [STREAK_W-1:0] streak, streak_nxt;   // video wins while the CPU was waiting
    ar_req_t             ar_q, ar_nxt;
    logic                grant_cpu;
    logic                owner_r_ready;

    assign owner_r_ready = owner ? s1_r_ready : s0_r_ready;

    // Read data and last fan out to both masters; only r_valid is steered.
    assign s0_r_payload_data = m_r_payload_data;
    assign s0_r_payload_last = m_r_payload_last;
    assign s1_r_payload_data = m_r_payload_data;
    assign s1_r_payload_last = m_r_payload_last;

    assign m_ar_payload_addr  = ar_q.addr;
    assign m_ar_payload_len   = ar_q.len;
    assign m_ar_payload_burst = ar_q.burst;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            streak <= '0;
            ar_q   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            streak <= streak_nxt;
            ar_q   <= ar_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        streak_nxt  = streak;
        ar_nxt      = ar_q;
        grant_cpu   = 1'b0;
        s0_ar_ready = 1'b0;
        s1_ar_ready = 1'b0;
        m_ar_valid  = 1'b0;
        m_r_ready   = 1'b1;   // outside DATA any stray beat is sunk
        s0_r_valid  = 1'b0;
        s1_r_valid  = 1'b0;

        // While reset is held nothing handshakes, so no requester can lose a grant.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (s0_ar_valid || s1_ar_valid) begin
                        // Video wins ties until it has beaten a waiting CPU MAX times in a row.
                        grant_cpu = s1_ar_valid && (!s0_ar_valid || streak == STREAK_MAX);
                        state_nxt = ADDR;
                        if (grant_cpu) begin
                            s1_ar_ready = 1'b1;
                            owner_nxt   = 1'b1;
                            streak_nxt  = '0;
                            ar_nxt      = '{addr: s1_ar_payload_addr, len: s1_ar_payload_len,
                                            burst: s1_ar_payload_burst};
                        end else begin
                            s0_ar_ready = 1'b1;
                            owner_nxt   = 1'b0;
                            ar_nxt      = '{addr: s0_ar_payload_addr, len: s0_ar_payload_len,
                                            burst: s0_ar_payload_burst};
                            if (s1_ar_valid && streak != STREAK_MAX) begin
                                streak_nxt = streak + STREAK_W'(1);
                            end
                        end
                    end
                end
                ADDR: begin
                    m_ar_valid = 1'b1;
                    if (m_ar_ready) begin
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    m_r_ready  = owner_r_ready;
                    s0_r_valid = m_r_valid && !owner;
                    s1_r_valid = m_r_valid && owner;
                    // Only last ends the burst; len is never counted here.
                    if (m_r_valid && owner_r_ready && m_r_payload_last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios plus randomized bursts against a reference model.
// Latency: n/a.
// Backpressure: bench drives random gaps on m_r_valid, m_ar_ready and the masters' r_ready.
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    localparam int MAXS = 4;

    logic              clk, reset;
    logic              s0_ar_valid, s0_ar_ready;
    logic [ADDR_W-1:0] s0_ar_payload_addr;
    logic [LEN_W-1:0]  s0_ar_payload_len;
    logic [1:0]        s0_ar_payload_burst;
    logic              s0_r_valid, s0_r_ready;
    logic [DATA_W-1:0] s0_r_payload_data;
    logic              s0_r_payload_last;
    logic              s1_ar_valid, s1_ar_ready;
    logic [ADDR_W-1:0] s1_ar_payload_addr;
    logic [LEN_W-1:0]  s1_ar_payload_len;
    logic [1:0]        s1_ar_payload_burst;
    logic              s1_r_valid, s1_r_ready;
    logic [DATA_W-1:0] s1_r_payload_data;
    logic              s1_r_payload_last;
    logic              m_ar_valid, m_ar_ready;
    logic [ADDR_W-1:0] m_ar_payload_addr;
    logic [LEN_W-1:0]  m_ar_payload_len;
    logic [1:0]        m_ar_payload_burst;
    logic              m_r_valid, m_r_ready;
    logic [DATA_W-1:0] m_r_payload_data;
    logic              m_r_payload_last;

    int n_checks = 0;
    int n_pass   = 0;

    mem_read_arbiter #(.MAX_VIDEO_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready),
        .s0_ar_payload_addr(s0_ar_payload_addr), .s0_ar_payload_len(s0_ar_payload_len),
        .s0_ar_payload_burst(s0_ar_payload_burst),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
        .s0_r_payload_data(s0_r_payload_data), .s0_r_payload_last(s0_r_payload_last),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready),
        .s1_ar_payload_addr(s1_ar_payload_addr), .s1_ar_payload_len(s1_ar_payload_len),
        .s1_ar_payload_burst(s1_ar_payload_burst),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
        .s1_r_payload_data(s1_r_payload_data), .s1_r_payload_last(s1_r_payload_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_payload_addr(m_ar_payload_addr), .m_ar_payload_len(m_ar_payload_len),
        .m_ar_payload_burst(m_ar_payload_burst),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_payload_data(m_r_payload_data), .m_r_payload_last(m_r_payload_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_ar_valid = 0; s0_ar_payload_addr = '0; s0_ar_payload_len = '0; s0_ar_payload_burst = '0;
        s1_ar_valid = 0; s1_ar_payload_addr = '0; s1_ar_payload_len = '0; s1_ar_payload_burst = '0;
        s0_r_ready = 1; s1_r_ready = 1; m_ar_ready = 0;
        m_r_valid = 0; m_r_payload_data = '0; m_r_payload_last = 0;
    endtask

    // Waits (bounded) for an address grant; returns in the grant cycle. who: 0/1, 2 = both, -1 = none.
    task automatic wait_grant(output int who, output bit to);
        who = -1;
        to  = 1;
        for (int c = 0; c < 20; c++) begin
            #2;
            if (s0_ar_ready || s1_ar_ready) begin
                who = (s0_ar_ready && s1_ar_ready) ? 2 : (s1_ar_ready ? 1 : 0);
                to  = 0;
                return;
            end
            tick();
        end
    endtask

    // Memory model for one burst in DATA: n beats, random valid gaps and owner stalls.
    // Collects how many beats the owner received intact and how many cycles broke the R rules.
    task automatic serve_beats(input int n, input int own, input int gap_pct, input int stall_pct,
                               output int good, output int errs, output bit to);
        logic [DATA_W-1:0] beat;
        logic              ovld, olast, nvld, ordy;
        logic [DATA_W-1:0] odat;
        int                i, cyc;
        bit                held;
        good = 0; errs = 0; to = 0; i = 0; cyc = 0; held = 0;
        beat = {$urandom, $urandom};
        while (i < n) begin
            if (cyc >= 100 + 20 * n) begin
                to = 1;
                break;
            end
            m_r_valid        = held || ($urandom_range(99) >= gap_pct);
            m_r_payload_data = beat;
            m_r_payload_last = (i == n - 1);
            ordy             = ($urandom_range(99) >= stall_pct);
            if (own == 1) begin
                s1_r_ready = ordy; s0_r_ready = 1'($urandom_range(1));
            end else begin
                s0_r_ready = ordy; s1_r_ready = 1'($urandom_range(1));
            end
            #2;
            ovld  = (own == 1) ? s1_r_valid : s0_r_valid;
            odat  = (own == 1) ? s1_r_payload_data : s0_r_payload_data;
            olast = (own == 1) ? s1_r_payload_last : s0_r_payload_last;
            nvld  = (own == 1) ? s0_r_valid : s1_r_valid;
            if (ovld !== m_r_valid || nvld !== 1'b0 || m_r_ready !== ordy) errs++;
            if (m_r_valid && ordy) begin
                if (ovld === 1'b1 && odat === beat && olast === (i == n - 1)) good++;
                else errs++;
                i++;
                beat = {$urandom, $urandom};
                held = 0;
            end else begin
                held = m_r_valid;
            end
            tick();
            cyc++;
        end
        m_r_valid = 0;
        m_r_payload_last = 0;
        s0_r_ready = 1;
        s1_r_ready = 1;
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] stray;
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        stray = 64'hDEAD_BEEF_0123_4567;
        m_r_valid = 1; m_r_payload_data = stray; m_r_payload_last = 1;
        #2;
        n_checks++;
        if (m_ar_valid !== 1'b0) $display("FAIL reset_m_ar_valid: got %b want 0", m_ar_valid);
        else n_pass++;
        n_checks++;
        if ({s0_ar_ready, s1_ar_ready} !== 2'b00)
            $display("FAIL reset_ar_ready: got %b want 00", {s0_ar_ready, s1_ar_ready});
        else n_pass++;
        n_checks++;
        if ({s0_r_valid, s1_r_valid} !== 2'b00)
            $display("FAIL reset_r_valid: got %b want 00", {s0_r_valid, s1_r_valid});
        else n_pass++;
        n_checks++;
        if (m_r_ready !== 1'b1) $display("FAIL reset_m_r_ready: got %b want 1", m_r_ready);
        else n_pass++;
        n_checks++;
        if ({m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst} !== 42'd0)
            $display("FAIL reset_ar_payload: got %h/%h/%h want 0/0/0",
                     m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst);
        else n_pass++;
        n_checks++;
        if (s0_r_payload_data !== stray || s1_r_payload_data !== stray || s1_r_payload_last !== 1'b1)
            $display("FAIL reset_r_data_fanout: got %h/%h want %h", s0_r_payload_data, s1_r_payload_data, stray);
        else n_pass++;
        tick();
        m_r_valid = 0; m_r_payload_last = 0;
    endtask

    task automatic test_single_video();
        int good, errs;
        bit to;
        s0_ar_valid = 1; s0_ar_payload_addr = 32'h0010_0000; s0_ar_payload_len = 8'd31; s0_ar_payload_burst = 2'd1;
        m_ar_ready = 0;
        #2;
        n_checks++;
        if ({s0_ar_ready, s1_ar_ready, m_ar_valid} !== 3'b100)
            $display("FAIL video_grant_cycle: got s0r/s1r/mav=%b want 100", {s0_ar_ready, s1_ar_ready, m_ar_valid});
        else n_pass++;
        tick();
        s0_ar_valid = 0; s0_ar_payload_addr = 32'hFFFF_FFFF; s0_ar_payload_len = 8'd0; s0_ar_payload_burst = 2'd3;
        #2;
        n_checks++;
        if (m_ar_valid !== 1'b1) $display("FAIL video_ar_latency: got m_ar_valid=%b want 1", m_ar_valid);
        else n_pass++;
        n_checks++;
        if (m_ar_payload_addr !== 32'h0010_0000 || m_ar_payload_len !== 8'd31 || m_ar_payload_burst !== 2'd1)
            $display("FAIL video_ar_payload: got %h/%0d/%0d want 00100000/31/1",
                     m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst);
        else n_pass++;
        m_ar_ready = 1;
        tick();
        m_ar_ready = 0;
        serve_beats(32, 0, 30, 0, good, errs, to);
        n_checks++;
        if (good != 32 || errs != 0 || to)
            $display("FAIL video_burst_beats: got good=%0d errs=%0d timeout=%0d want 32/0/0", good, errs, to);
        else n_pass++;
    endtask

    task automatic test_grant_order();
        int  who, want, good, errs, order_bad, pay_bad, beat_bad;
        bit  to;
        logic [41:0] p0, p1, granted;
        order_bad = 0; pay_bad = 0; beat_bad = 0;
        p0 = {$urandom, 10'($urandom)};
        p1 = {$urandom, 10'($urandom)};
        s0_ar_valid = 1; s1_ar_valid = 1; m_ar_ready = 1;
        {s0_ar_payload_addr, s0_ar_payload_len, s0_ar_payload_burst} = p0;
        {s1_ar_payload_addr, s1_ar_payload_len, s1_ar_payload_burst} = p1;
        for (int k = 0; k < 10; k++) begin
            wait_grant(who, to);
            want = (k % (MAXS + 1) == MAXS) ? 1 : 0;   // every fifth grant goes to the CPU
            if (to || who != want) begin
                order_bad++;
                $display("FAIL grant_order[%0d]: got master %0d want %0d", k, who, want);
            end
            granted = (want == 1) ? p1 : p0;
            tick();
            if (want == 1) begin
                p1 = {$urandom, 10'($urandom)};
                {s1_ar_payload_addr, s1_ar_payload_len, s1_ar_payload_burst} = p1;
            end else begin
                p0 = {$urandom, 10'($urandom)};
                {s0_ar_payload_addr, s0_ar_payload_len, s0_ar_payload_burst} = p0;
            end
            #2;
            if (m_ar_valid !== 1'b1 || {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst} !== granted) pay_bad++;
            tick();
            serve_beats(1, want, 0, 0, good, errs, to);
            if (good != 1 || errs != 0 || to) beat_bad++;
        end
        s0_ar_valid = 0; s1_ar_valid = 0; m_ar_ready = 0;
        n_checks++;
        if (order_bad != 0) $display("FAIL grant_order_total: got %0d wrong grants want 0", order_bad);
        else n_pass++;
        n_checks++;
        if (pay_bad != 0) $display("FAIL grant_order_payload: got %0d bad AR cycles want 0", pay_bad);
        else n_pass++;
        n_checks++;
        if (beat_bad != 0) $display("FAIL grant_order_beats: got %0d bad bursts want 0", beat_bad);
        else n_pass++;
    endtask

    task automatic test_r_backpressure();
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] got_q[$];
        int who, i, c, errs, lows, data_bad;
        bit to;
        for (int b = 0; b < 8; b++) exp_q.push_back({$urandom, $urandom});
        s1_ar_valid = 1; s1_ar_payload_addr = $urandom; s1_ar_payload_len = 8'd7; s1_ar_payload_burst = 2'd1;
        m_ar_ready = 1;
        wait_grant(who, to);
        n_checks++;
        if (to || who != 1) $display("FAIL bp_grant: got master %0d want 1", who);
        else n_pass++;
        tick();
        s1_ar_valid = 0;
        tick();
        m_ar_ready = 0;
        i = 0; c = 0; errs = 0; lows = 0;
        while (i < 8 && c < 60) begin
            m_r_valid = 1; m_r_payload_data = exp_q[i]; m_r_payload_last = (i == 7);
            s1_r_ready = !(c >= 3 && c < 6);
            s0_r_ready = 1;
            #2;
            if (m_r_ready !== s1_r_ready) errs++;
            if (m_r_ready === 1'b0) lows++;
            if (s1_r_valid !== 1'b1 || s0_r_valid !== 1'b0) errs++;
            if (s1_r_valid && m_r_ready) got_q.push_back(s1_r_payload_data);
            if (s1_r_ready) i++;
            tick();
            c++;
        end
        m_r_valid = 0; m_r_payload_last = 0; s1_r_ready = 1;
        data_bad = (got_q.size() == 8) ? 0 : 1;
        for (int b = 0; b < 8 && b < got_q.size(); b++) if (got_q[b] !== exp_q[b]) data_bad++;
        n_checks++;
        if (errs != 0) $display("FAIL bp_ready_follow: got %0d bad cycles want 0", errs);
        else n_pass++;
        n_checks++;
        if (lows != 3) $display("FAIL bp_low_cycles: got m_r_ready low %0d cycles want 3", lows);
        else n_pass++;
        n_checks++;
        if (data_bad != 0) $display("FAIL bp_sequence: got %0d beats, %0d errors want 8 beats, 0 errors", got_q.size(), data_bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int who, pre_bad, vld_bad, rdy_bad, good, errs;
        bit to;
        logic [41:0] p1;
        pre_bad = 0; vld_bad = 0; rdy_bad = 0;
        s0_ar_valid = 1; s0_ar_payload_addr = $urandom; s0_ar_payload_len = 8'd31; s0_ar_payload_burst = 2'd1;
        m_ar_ready = 1;
        wait_grant(who, to);
        tick();
        s0_ar_valid = 0;
        tick();
        m_ar_ready = 0;
        for (int b = 0; b < 5; b++) begin
            m_r_valid = 1; m_r_payload_data = {$urandom, $urandom}; m_r_payload_last = 0;
            #2;
            if (s0_r_valid !== 1'b1) pre_bad++;
            tick();
        end
        reset = 1; m_r_valid = 0;
        tick();
        reset = 0;
        for (int b = 0; b < 27; b++) begin
            m_r_valid = 1; m_r_payload_data = {$urandom, $urandom}; m_r_payload_last = (b == 26);
            s0_r_ready = 1'($urandom_range(1)); s1_r_ready = 1'($urandom_range(1));
            #2;
            if (s0_r_valid !== 1'b0 || s1_r_valid !== 1'b0) vld_bad++;
            if (m_r_ready !== 1'b1) rdy_bad++;
            tick();
        end
        m_r_valid = 0; m_r_payload_last = 0; s0_r_ready = 1; s1_r_ready = 1;
        n_checks++;
        if (pre_bad != 0 || to || who != 0) $display("FAIL rst_pre_beats: got %0d bad (grant %0d) want 0 (grant 0)", pre_bad, who);
        else n_pass++;
        n_checks++;
        if (vld_bad != 0) $display("FAIL rst_drop_valid: got %0d cycles with r_valid want 0", vld_bad);
        else n_pass++;
        n_checks++;
        if (rdy_bad != 0) $display("FAIL rst_drop_ready: got %0d cycles m_r_ready low want 0", rdy_bad);
        else n_pass++;
        p1 = {$urandom, 8'd3, 2'd1};
        s1_ar_valid = 1; {s1_ar_payload_addr, s1_ar_payload_len, s1_ar_payload_burst} = p1;
        m_ar_ready = 1;
        wait_grant(who, to);
        tick();
        s1_ar_valid = 0;
        #2;
        n_checks++;
        if (to || who != 1 || m_ar_valid !== 1'b1 || {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst} !== p1)
            $display("FAIL rst_fresh_ar: got master %0d payload %h want 1 / %h", who,
                     {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst}, p1);
        else n_pass++;
        tick();
        m_ar_ready = 0;
        serve_beats(4, 1, 20, 20, good, errs, to);
        n_checks++;
        if (good != 4 || errs != 0 || to) $display("FAIL rst_fresh_burst: got good=%0d errs=%0d to=%0d want 4/0/0", good, errs, to);
        else n_pass++;
    endtask

    task automatic test_ar_stall_then_last();
        logic [41:0] p0, p1;
        int stall_bad, good, errs;
        bit to;
        stall_bad = 0;
        p0 = {$urandom, 8'd0, 2'd1};
        p1 = {$urandom, 8'd0, 2'd2};
        m_ar_ready = 0;
        s0_ar_valid = 1; {s0_ar_payload_addr, s0_ar_payload_len, s0_ar_payload_burst} = p0;
        #2;
        n_checks++;
        if (s0_ar_ready !== 1'b1) $display("FAIL stall_grant: got s0_ar_ready=%b want 1", s0_ar_ready);
        else n_pass++;
        tick();
        s0_ar_valid = 0;
        s1_ar_valid = 1; {s1_ar_payload_addr, s1_ar_payload_len, s1_ar_payload_burst} = p1;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (m_ar_valid !== 1'b1 || {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst} !== p0 ||
                s0_ar_ready !== 1'b0 || s1_ar_ready !== 1'b0) stall_bad++;
            tick();
        end
        n_checks++;
        if (stall_bad != 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_bad);
        else n_pass++;
        m_ar_ready = 1;
        tick();
        m_ar_ready = 0;
        m_r_valid = 1; m_r_payload_data = {$urandom, $urandom}; m_r_payload_last = 1; s0_r_ready = 1;
        #2;
        n_checks++;
        if (s1_ar_ready !== 1'b0 || s0_r_valid !== 1'b1)
            $display("FAIL last_cycle_T: got s1_ar_ready=%b s0_r_valid=%b want 0/1", s1_ar_ready, s0_r_valid);
        else n_pass++;
        tick();
        m_r_valid = 0; m_r_payload_last = 0;
        #2;
        n_checks++;
        if (s1_ar_ready !== 1'b1 || m_ar_valid !== 1'b0)
            $display("FAIL last_cycle_T1: got s1_ar_ready=%b m_ar_valid=%b want 1/0", s1_ar_ready, m_ar_valid);
        else n_pass++;
        tick();
        s1_ar_valid = 0;
        #2;
        n_checks++;
        if (m_ar_valid !== 1'b1 || {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst} !== p1)
            $display("FAIL last_cycle_T2: got m_ar_valid=%b payload %h want 1 / %h", m_ar_valid,
                     {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst}, p1);
        else n_pass++;
        m_ar_ready = 1;
        tick();
        m_ar_ready = 0;
        serve_beats(1, 1, 0, 0, good, errs, to);
        n_checks++;
        if (good != 1 || errs != 0 || to) $display("FAIL last_cpu_burst: got good=%0d errs=%0d to=%0d want 1/0/0", good, errs, to);
        else n_pass++;
    endtask

    // Reference: pending requests persist until granted; the CPU wins when alone or once the
    // video master has beaten a waiting CPU MAXS times since the CPU last won.
    task automatic test_random();
        bit          pend0, pend1, to;
        logic [41:0] pay0, pay1, want_pay;
        int          run, who, want, stall_n, ar_bad, good, errs, nbeats;
        pend0 = 0; pend1 = 0; run = 0;
        idle_inputs();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        for (int it = 0; it < 40; it++) begin
            if (!pend0 && $urandom_range(99) < 75) begin pend0 = 1; pay0 = {$urandom, 8'($urandom_range(7)), 2'($urandom)}; end
            if (!pend1 && $urandom_range(99) < 50) begin pend1 = 1; pay1 = {$urandom, 8'($urandom_range(7)), 2'($urandom)}; end
            if (!pend0 && !pend1) begin pend1 = 1; pay1 = {$urandom, 8'($urandom_range(7)), 2'($urandom)}; end
            s0_ar_valid = pend0; {s0_ar_payload_addr, s0_ar_payload_len, s0_ar_payload_burst} = pay0;
            s1_ar_valid = pend1; {s1_ar_payload_addr, s1_ar_payload_len, s1_ar_payload_burst} = pay1;
            want = (pend0 && pend1) ? ((run == MAXS) ? 1 : 0) : (pend1 ? 1 : 0);
            wait_grant(who, to);
            n_checks++;
            if (to || who != want) $display("FAIL rand_grant[%0d]: got master %0d want %0d", it, who, want);
            else n_pass++;
            if (want == 1) run = 0;
            else if (pend1) run = (run < MAXS) ? run + 1 : run;
            want_pay = (want == 1) ? pay1 : pay0;
            if (want == 1) pend1 = 0; else pend0 = 0;
            tick();
            s0_ar_valid = pend0; s1_ar_valid = pend1;
            ar_bad = 0;
            stall_n = $urandom_range(3);
            for (int s = 0; s <= stall_n; s++) begin
                m_ar_ready = (s == stall_n);
                #2;
                if (m_ar_valid !== 1'b1 || {m_ar_payload_addr, m_ar_payload_len, m_ar_payload_burst} !== want_pay ||
                    s0_ar_ready !== 1'b0 || s1_ar_ready !== 1'b0) ar_bad++;
                tick();
            end
            m_ar_ready = 0;
            n_checks++;
            if (ar_bad != 0) $display("FAIL rand_ar[%0d]: got %0d bad AR cycles want 0", it, ar_bad);
            else n_pass++;
            nbeats = int'(want_pay[9:2]) + 1;
            serve_beats(nbeats, want, 25, 25, good, errs, to);
            n_checks++;
            if (good != nbeats || errs != 0 || to)
                $display("FAIL rand_burst[%0d]: got good=%0d errs=%0d to=%0d want %0d/0/0", it, good, errs, to, nbeats);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_video();
        test_grant_order();
        test_r_backpressure();
        test_reset_mid_burst();
        test_ar_stall_then_last();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
